// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule stage.
// Accepts one 512-bit padded block and streams the schedule words W[0..P_ROUNDS-1] to the
// compression round datapath, one word per output handshake.
//
// Parameters:
//   P_ROUNDS    : words streamed per block (17..64), last index is P_ROUNDS-1
//   P_BACK2BACK : 1 lets a new block be accepted in the last word's handshake cycle
//
// Ports:
//   i_clk       : rising-edge clock
//   i_reset     : synchronous active-high reset
//   i_blk_valid : upstream block available
//   o_blk_ready : block accepted when i_blk_valid & o_blk_ready
//   i_blk_data  : block, big-endian (W[0] = i_blk_data[511:480])
//   o_w_valid   : schedule word available
//   i_w_ready   : downstream accepts word when o_w_valid & i_w_ready
//   o_w_data    : W[o_w_idx]
//   o_w_idx     : round index of o_w_data
//   o_w_last    : high while o_w_idx == P_ROUNDS-1 and o_w_valid is high
module sha256_msg_sched #(
  parameter int unsigned P_ROUNDS    = 64,
  parameter bit          P_BACK2BACK = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [511:0] i_blk_data,
  output logic         o_w_valid,
  input  logic         i_w_ready,
  output logic [31:0]  o_w_data,
  output logic [5:0]   o_w_idx,
  output logic         o_w_last
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [5:0] LP_LAST = 6'(P_ROUNDS - 1);

  state_e      r_state;
  logic [31:0] r_win [16];
  logic [5:0]  r_idx;

  logic        w_run;
  logic        w_last;
  logic        w_blk_ready;
  logic        w_blk_hs;
  logic [31:0] w_next;

  // Small sigma helpers of the SHA-256 schedule recurrence.
  function automatic logic [31:0] f_sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] f_sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign w_run       = (r_state == StRun);
  assign w_last      = w_run && (r_idx == LP_LAST);
  // In RUN a new block is only taken while the final word is leaving.
  assign w_blk_ready = !w_run || (P_BACK2BACK && i_w_ready && w_last);
  assign w_blk_hs    = i_blk_valid && w_blk_ready;

  // win[0] is W[t], so win[15] receives W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
  assign w_next = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_idx   <= 6'd0;
      for (int i = 0; i < 16; i++) r_win[i] <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_blk_valid) begin
            for (int i = 0; i < 16; i++) r_win[i] <= i_blk_data[511-32*i -: 32];
            r_idx   <= 6'd0;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (i_w_ready) begin
            if (w_last) begin
              r_idx <= 6'd0;
              if (w_blk_hs) begin
                for (int i = 0; i < 16; i++) r_win[i] <= i_blk_data[511-32*i -: 32];
              end else begin
                r_state <= StIdle;
              end
            end else begin
              for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
              r_win[15] <= w_next;
              r_idx     <= r_idx + 6'd1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_blk_ready = w_blk_ready;
  assign o_w_valid   = w_run;
  assign o_w_data    = r_win[0];
  assign o_w_idx     = r_idx;
  assign o_w_last    = w_last;

endmodule

// File: tb/tb_sha256_msg_sched.sv
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         blk_valid, blk_ready, w_valid, w_ready, w_last;
  logic [511:0] blk_data;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;

  // Second instance: short schedule, no back-to-back acceptance.
  logic         blk_valid0, blk_ready0, w_valid0, w_ready0, w_last0;
  logic [511:0] blk_data0;
  logic [31:0]  w_data0;
  logic [5:0]   w_idx0;

  sha256_msg_sched #(.P_ROUNDS(64), .P_BACK2BACK(1'b1)) dut (
    .i_clk(clk), .i_reset(reset), .i_blk_valid(blk_valid), .o_blk_ready(blk_ready),
    .i_blk_data(blk_data), .o_w_valid(w_valid), .i_w_ready(w_ready), .o_w_data(w_data),
    .o_w_idx(w_idx), .o_w_last(w_last)
  );

  sha256_msg_sched #(.P_ROUNDS(17), .P_BACK2BACK(1'b0)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_blk_valid(blk_valid0), .o_blk_ready(blk_ready0),
    .i_blk_data(blk_data0), .o_w_valid(w_valid0), .i_w_ready(w_ready0), .o_w_data(w_data0),
    .o_w_idx(w_idx0), .o_w_last(w_last0)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] m_w [64];
  logic [31:0] obs [64];

  typedef struct {
    int          idx;
    logic [31:0] w;
  } vec_t;
  vec_t tbl [5];

  logic [511:0] abc_blk;
  logic [511:0] blk_a, blk_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
  task automatic model(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        m_w[t] = blk[511-32*t -: 32];
      end else begin
        s0 = rotr(m_w[t-15], 7) ^ rotr(m_w[t-15], 18) ^ (m_w[t-15] >> 3);
        s1 = rotr(m_w[t-2], 17) ^ rotr(m_w[t-2], 19) ^ (m_w[t-2] >> 10);
        m_w[t] = s1 + m_w[t-7] + s0 + m_w[t-16];
      end
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the handshake.
  task automatic accept_block(input logic [511:0] blk);
    blk_valid = 1'b1;
    blk_data  = blk;
    w_ready   = 1'($urandom_range(1));
    #1;
    chk("idle_blk_ready", 64'(blk_ready), 64'd1);
    chk("idle_w_valid", 64'(w_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  // Consumes 64 words against m_w. b2b: caller holds blk_valid/blk_data for the next block.
  task automatic stream_words(input int pct, input bit junk, input bit b2b);
    int t;
    int budget;
    t = 0;
    budget = 5000;
    while (t < 64 && budget > 0) begin
      budget--;
      w_ready = (pct >= 100) ? 1'b1 : (($urandom_range(99) < 32'(pct)) ? 1'b1 : 1'b0);
      if (!b2b) begin
        blk_valid = (junk && t != 63) ? 1'($urandom_range(1)) : 1'b0;
        if (junk) blk_data = rand_block();
      end
      #1;
      chk("w_valid", 64'(w_valid), 64'd1);
      chk("w_idx", 64'(w_idx), 64'(t));
      chk("w_data", 64'(w_data), 64'(m_w[t]));
      chk("w_last", 64'(w_last), 64'(t == 63));
      chk("blk_ready_run", 64'(blk_ready), 64'((t == 63) && w_ready));
      obs[t] = w_data;
      if (w_ready) t++;
      @(posedge clk);
      @(negedge clk);
    end
    if (t < 64) chk("stream_timeout", 64'(t), 64'd64);
  endtask

  task automatic check_abc_table();
    for (int i = 0; i < 5; i++)
      chk($sformatf("abc_W%0d", tbl[i].idx), 64'(obs[tbl[i].idx]), 64'(tbl[i].w));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{idx: 0,  w: 32'h61626380};
    tbl[1] = '{idx: 15, w: 32'h00000018};
    tbl[2] = '{idx: 16, w: 32'h61626380};
    tbl[3] = '{idx: 17, w: 32'h000F0000};
    tbl[4] = '{idx: 63, w: 32'h12B1EDEB};
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;

    reset = 1'b1;
    blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
    blk_valid0 = 1'b0; blk_data0 = '0; w_ready0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_w_valid", 64'(w_valid), 64'd0);
    chk("rst_w_data", 64'(w_data), 64'd0);
    chk("rst_w_idx", 64'(w_idx), 64'd0);
    chk("rst_w_last", 64'(w_last), 64'd0);
    chk("rst_blk_ready", 64'(blk_ready), 64'd1);

    // "abc" block, w_ready always high.
    model(abc_blk);
    accept_block(abc_blk);
    stream_words(100, 1'b0, 1'b0);
    check_abc_table();

    // All-zero block: 64 zero words, then back to IDLE.
    model('0);
    accept_block('0);
    stream_words(100, 1'b0, 1'b0);
    #1;
    chk("zero_end_w_valid", 64'(w_valid), 64'd0);
    chk("zero_end_blk_ready", 64'(blk_ready), 64'd1);

    // "abc" under random backpressure.
    model(abc_blk);
    accept_block(abc_blk);
    stream_words(50, 1'b0, 1'b0);
    check_abc_table();

    // Back-to-back blocks with blk_valid held high.
    blk_a = rand_block();
    blk_b = rand_block();
    model(blk_a);
    accept_block(blk_a);
    blk_valid = 1'b1;
    blk_data  = blk_b;
    stream_words(100, 1'b0, 1'b1);
    model(blk_b);
    #1;
    chk("b2b_no_bubble_valid", 64'(w_valid), 64'd1);
    chk("b2b_no_bubble_idx", 64'(w_idx), 64'd0);
    stream_words(100, 1'b0, 1'b0);

    // Reset mid-block at index 20.
    model(abc_blk);
    accept_block(abc_blk);
    w_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("pre_rst_idx", 64'(w_idx), 64'(k));
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    chk("rst_at_idx", 64'(w_idx), 64'd20);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    w_ready = 1'b0;
    #1;
    chk("midrst_w_valid", 64'(w_valid), 64'd0);
    chk("midrst_w_idx", 64'(w_idx), 64'd0);
    chk("midrst_w_data", 64'(w_data), 64'd0);
    chk("midrst_blk_ready", 64'(blk_ready), 64'd1);
    accept_block(abc_blk);
    stream_words(100, 1'b0, 1'b0);
    check_abc_table();

    // Short schedule with a mandatory idle cycle between blocks.
    blk_a = rand_block();
    model(blk_a);
    blk_valid0 = 1'b1;
    blk_data0  = blk_a;
    w_ready0   = 1'b1;
    for (int k = 0; k < 38; k++) begin
      int ph;
      ph = k % 18;
      #1;
      if (ph == 0) begin
        chk("nb2b_idle_valid", 64'(w_valid0), 64'd0);
        chk("nb2b_idle_ready", 64'(blk_ready0), 64'd1);
      end else begin
        chk("nb2b_valid", 64'(w_valid0), 64'd1);
        chk("nb2b_idx", 64'(w_idx0), 64'(ph - 1));
        chk("nb2b_data", 64'(w_data0), 64'(m_w[ph-1]));
        chk("nb2b_last", 64'(w_last0), 64'(ph == 17));
        chk("nb2b_blk_ready", 64'(blk_ready0), 64'd0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    blk_valid0 = 1'b0;
    w_ready0   = 1'b0;

    // Random blocks, random backpressure, stray blk_valid pulses during RUN.
    for (int n = 0; n < 300; n++) begin
      blk_a = rand_block();
      model(blk_a);
      accept_block(blk_a);
      stream_words(70, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
